div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_if.sv | 21 ++
 rtl/div_unit.sv | 130 +++++++++++++
 tb/tb_div_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Operand/result bundle between the control FSM (master) and the divider (slave).
interface div_if;
  logic        div_ctrl;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_end;
  logic        div_zero;
  logic        div_busy;

  modport master (
    output div_ctrl, a, b,
    input  hi, lo, div_end, div_zero, div_busy
  );

  modport slave (
    input  div_ctrl, a, b,
    output hi, lo, div_end, div_zero, div_busy
  );
endinterface

// File: rtl/div_unit.sv
// Signed 32-bit restoring divider, one quotient bit per cycle.
// lo = quotient (truncated toward zero), hi = remainder (sign of dividend).
module div_unit (
  input  logic clock,
  input  logic reset,
  div_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic        ctrl_prev_q, ctrl_prev_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dsr_q, dsr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        end_q, end_d;
  logic        zero_q, zero_d;
  logic        busy_q, busy_d;

  logic        start;
  logic [33:0] rem_sh;
  logic        rem_ge;

  always_comb begin
    start  = bus.div_ctrl & ~ctrl_prev_q;
    // Dividend bits shift out of quo_q into the partial remainder.
    rem_sh = {rem_q, quo_q[31]};
    rem_ge = rem_sh >= {2'b00, dsr_q};

    state_d     = state_q;
    ctrl_prev_d = bus.div_ctrl;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dsr_d       = dsr_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    end_d       = 1'b0;
    zero_d      = 1'b0;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (bus.b == '0) begin
            end_d   = 1'b1;
            zero_d  = 1'b1;
            state_d = DONE;
          end else begin
            dsr_d     = bus.b[31] ? -bus.b : bus.b;
            quo_d     = bus.a[31] ? -bus.a : bus.a;
            neg_rem_d = bus.a[31];
            neg_quo_d = bus.a[31] ^ bus.b[31];
            cnt_d     = '0;
            rem_d     = '0;
            busy_d    = 1'b1;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        if (rem_ge) begin
          rem_d = rem_sh[32:0] - {1'b0, dsr_q};
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = rem_sh[32:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = FIX;
      end
      FIX: begin
        lo_d    = neg_quo_q ? -quo_q : quo_q;
        hi_d    = neg_rem_q ? -rem_q[31:0] : rem_q[31:0];
        end_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ctrl_prev_q <= 1'b0;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      end_q       <= 1'b0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_prev_q <= ctrl_prev_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dsr_q       <= dsr_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      end_q       <= end_d;
      zero_q      <= zero_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_end  = end_q;
  assign bus.div_zero = zero_q;
  assign bus.div_busy = busy_q;
endmodule

// File: tb/tb_div_unit.sv
// Scoreboarded bench for div_unit: stimulus pushes expected results, a monitor checks them on div_end.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ends = 0;

  div_if dif();

  div_unit u_dut (
    .clock (clk),
    .reset (rst),
    .bus   (dif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;
    int          start_cyc;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] m_lo = '0;
  logic [31:0] m_hi = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: plain signed division; divide-by-zero leaves prior results.
  function automatic void push_exp(input logic [31:0] a, input logic [31:0] b, input int start_cyc);
    exp_t e;
    int   sa;
    int   sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      e.zero = 1'b1;
      e.lat  = 1;
    end else begin
      e.zero = 1'b0;
      e.lat  = 34;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        m_lo = 32'h8000_0000;
        m_hi = 32'd0;
      end else begin
        m_lo = sa / sb;
        m_hi = sa % sb;
      end
    end
    e.lo = m_lo;
    e.hi = m_hi;
    e.start_cyc = start_cyc;
    sbq.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (dif.div_zero && !dif.div_end) chk("zero_without_end", 32'(dif.div_zero), 32'd0);
      if (dif.div_end) begin
        ends++;
        if (sbq.size() == 0) begin
          chk("unexpected_div_end", 32'(dif.div_end), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("lo", dif.lo, e.lo);
          chk("hi", dif.hi, e.hi);
          chk("div_zero", 32'(dif.div_zero), 32'(e.zero));
          chk("latency", 32'(cyc - e.start_cyc + 1), 32'(e.lat));
        end
      end
    end
  end

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input int hold, input bit poke);
    int e0;
    @(negedge clk);
    dif.a = a;
    dif.b = b;
    dif.div_ctrl = 1'b1;
    e0 = ends;
    push_exp(a, b, cyc + 1);
    @(negedge clk);
    chk("busy_after_start", 32'(dif.div_busy), 32'(b != 32'd0));
    if (hold == 0) dif.div_ctrl = 1'b0;
    dif.a = $urandom;
    dif.b = $urandom;
    if (poke) begin
      repeat (8) @(negedge clk);
      dif.div_ctrl = 1'b1;
      @(negedge clk);
      dif.div_ctrl = 1'b0;
    end
    for (int i = 0; i < 60 && ends == e0; i++) @(negedge clk);
    if (ends == e0) begin
      chk("timeout_div_end", 32'd0, 32'd1);
      sbq.delete();
    end
    if (hold > 0 || poke) begin
      repeat (hold + 2) @(negedge clk);
      dif.div_ctrl = 1'b0;
      chk("single_div_end", 32'(ends - e0), 32'd1);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    dif.div_ctrl = 1'b0;
    dif.a = '0;
    dif.b = '0;
    #12;
    chk("rst_hi", dif.hi, 32'd0);
    chk("rst_lo", dif.lo, 32'd0);
    chk("rst_end", 32'(dif.div_end), 32'd0);
    chk("rst_zero", 32'(dif.div_zero), 32'd0);
    chk("rst_busy", 32'(dif.div_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_div(32'd100, 32'd7, 0, 1'b0);
    do_div(32'hFFFF_FF9C, 32'd7, 0, 1'b0);
    do_div(32'd100, 32'hFFFF_FFF9, 0, 1'b0);
    do_div(32'd20, 32'd3, 0, 1'b0);
    do_div(32'd5, 32'd0, 0, 1'b0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    do_div(32'h8000_0000, 32'd3, 0, 1'b0);
    do_div(32'h7FFF_FFFF, 32'h8000_0000, 0, 1'b0);
    do_div(32'd77, 32'd5, 40, 1'b0);
    do_div(32'd1000, 32'hFFFF_FFF9, 0, 1'b1);

    // Abort mid-CALC with div_ctrl already high so release starts a new division.
    @(negedge clk);
    dif.a = 32'd1000;
    dif.b = 32'd7;
    dif.div_ctrl = 1'b1;
    repeat (11) @(negedge clk);
    dif.a = 32'd9;
    dif.b = 32'd3;
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(dif.div_busy), 32'd0);
    chk("abort_hi", dif.hi, 32'd0);
    chk("abort_lo", dif.lo, 32'd0);
    chk("abort_end", 32'(dif.div_end), 32'd0);
    m_lo = '0;
    m_hi = '0;
    @(negedge clk);
    rst = 1'b0;
    push_exp(32'd9, 32'd3, cyc + 1);
    begin
      int e0;
      e0 = ends;
      @(negedge clk);
      dif.div_ctrl = 1'b0;
      for (int i = 0; i < 60 && ends == e0; i++) @(negedge clk);
      if (ends == e0) begin
        chk("timeout_after_reset", 32'd0, 32'd1);
        sbq.delete();
      end
    end

    for (int n = 0; n < 30; n++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'($signed($urandom_range(0, 40)) - 20);
        1: ra = 32'($signed($urandom_range(0, 2000)) - 1000);
        2: rb = 32'd0;
        default: ;
      endcase
      do_div(ra, rb, 0, 1'b0);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end
endmodule
